wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline interface: consumes the registered MEM/WB fields and performs load-data extraction and extension.
- Selects the write-back value and commits it into the 32x32 general register file.
- Provides two read ports to the decode stage with internal write-through bypass.
- Exposes the write-back value for forwarding into earlier stages.

Parameters:
- NREG, 32, number of architectural registers (register 0 hardwired to zero)
- DW, 32, data width
- CNTW, 32, width of the retired-write counter

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- RegWriteW  input  1  write enable from MEM/WB
- MemtoRegW  input  1  1 = write load data, 0 = write ALU result
- MemDataW  input  32  raw word read from data memory (word-aligned)
- ALUResultW  input  32  ALU result; for loads, the byte address
- RegisterRdW  input  5  destination register
- LsW  input  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others reserved
- RA1, RA2  input  5  decode read addresses
- RD1, RD2  output  32  decode read data
- WBData  output  32  combinational write-back value (forwarding source)
- WBWriteEn  output  1  effective write enable (RegWriteW and RegisterRdW != 0 and no fault)
- AlignFault  output  1  sticky misaligned-load flag
- WriteCount  output  CNTW  number of committed register writes

Behaviour:
- Reset asynchronous: all registers 0, AlignFault 0, WriteCount 0 immediately on Reset rise, held while Reset high.
- Combinational outputs (RD1, RD2, WBData, WBWriteEn) during reset: they reflect the zeroed register state.
- Load extraction when MemtoRegW=1, off = ALUResultW[1:0]:
  - lw: MemDataW
  - lb/lbu: byte at off (byte 0 = bits 7:0), sign-extended / zero-extended
  - lh/lhu: half at off[1] (0 = bits 15:0), sign-extended / zero-extended
  - reserved LsW: treated as lw
- MemtoRegW=0: WBData = ALUResultW; LsW ignored.
- Misalignment (only when MemtoRegW=1 and RegWriteW=1):
  - lw with off != 0, or lh/lhu with off[0]=1, is misaligned.
  - The write is suppressed (WBWriteEn=0).
  - AlignFault is set at the next Clk edge and stays 1 until Reset.
- Commit: at rising Clk, if WBWriteEn, reg[RegisterRdW] <= WBData and WriteCount increments.
  - WriteCount wraps modulo 2^CNTW.
  - Writes to register 0 are discarded and not counted.
- Read latency zero, combinational.
- RDn = 0 if RAn=0.
- Else RDn = WBData if WBWriteEn and RAn==RegisterRdW (same-cycle bypass).
- Else RDn = reg[RAn].
- Both ports may address the same register or the write register simultaneously; both see the bypassed value.
- Reset asserted between edges: the pending write is lost; no partial commit.

Decomposition:
- Shared package/header holds:
  - LsW encodings (LS_LW, LS_LB, LS_LBU, LS_LH, LS_LHU)
  - register-zero index constant
  - DW
- One natural sub-module: load_ext, a combinational extractor from (MemDataW, off, LsW) to extended data plus misalign flag.
- The register array, bypass and counter stay in the top module.

Test Plan:
- Reset then read all: assert Reset mid-cycle -> RD1/RD2 = 0 for RA = 0..31 immediately; WriteCount = 0; AlignFault = 0.
- ALU write plus bypass:
  - Stimulus: RegWriteW=1, MemtoRegW=0, ALUResultW=0x12345678, Rd=5, RA1=5 in the same cycle.
  - Response: RD1 = 0x12345678 before the edge and still after it; WriteCount = 1.
- Byte/half extension:
  - MemDataW=0x80FF7F01 with MemtoRegW=1.
  - lb off=3 -> 0xFFFFFF80
  - lbu off=3 -> 0x00000080
  - lb off=1 -> 0x0000007F
  - lh off=2 -> 0xFFFF80FF
  - lhu off=0 -> 0x00007F01
- Register 0: write 0xDEADBEEF to Rd=0 -> RD1 (RA1=0) = 0, WBWriteEn = 0, WriteCount unchanged.
- Misaligned load:
  - Stimulus: lw with ALUResultW=0x1002, Rd=7.
  - Response: no write (reg7 keeps its old value); AlignFault = 1 after the edge.
  - A subsequent valid write leaves AlignFault = 1.
- Counter wrap: with CNTW=4, perform 17 valid writes -> WriteCount = 1.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
// Shared definitions for the write-back stage and register file:
//   - DW          : datapath width
//   - REG_ZERO    : index of the hardwired-zero register
//   - ls_e        : load-type encodings carried on LsW
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

    localparam int DW = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        LS_LW  = 3'b000,
        LS_LB  = 3'b001,
        LS_LBU = 3'b010,
        LS_LH  = 3'b011,
        LS_LHU = 3'b100
    } ls_e;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_load_ext.sv
// -----------------------------------------------------------------------------
// load_ext
// Combinational load-data extractor. Picks the addressed byte/half out of the
// raw word-aligned memory word and sign- or zero-extends it. It also flags a
// misaligned access. The caller decides whether the flag matters.
//
// Ports:
//   mem_data  in   DW  raw word from data memory
//   off       in   2   byte offset within the word (address bits 1:0)
//   ls        in   3   load type (ls_e encoding; reserved codes act as lw)
//   data      out  DW  extracted and extended load value
//   misalign  out  1   lw with off != 0, or lh/lhu with odd off
// -----------------------------------------------------------------------------
module load_ext
    import wb_regfile_pkg::*;
(
    input  logic [DW-1:0] mem_data,
    input  logic [1:0]    off,
    input  logic [2:0]    ls,
    output logic [DW-1:0] data,
    output logic          misalign
);

    logic [DW-1:0] shifted;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;

    // Byte 0 sits in bits 7:0, so shifting right by 8*off brings the addressed
    // byte down to the bottom of the word.
    assign shifted  = mem_data >> {off, 3'b000};
    assign byte_val = shifted[7:0];
    assign half_val = off[1] ? mem_data[31:16] : mem_data[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data     = mem_data;
        misalign = 1'b0;
        case (ls_e'(ls))
            LS_LB:   data = {{(DW-8){byte_val[7]}}, byte_val};
            LS_LBU:  data = {{(DW-8){1'b0}}, byte_val};
            LS_LH: begin
                data     = {{(DW-16){half_val[15]}}, half_val};
                misalign = off[0];
            end
            LS_LHU: begin
                data     = {{(DW-16){1'b0}}, half_val};
                misalign = off[0];
            end
            // lw and every reserved encoding: the full word, which must be aligned.
            default: begin
                data     = mem_data;
                misalign = (off != 2'b00);
            end
        endcase
    end

endmodule : load_ext

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Write-back stage plus the general register file. It selects the write-back
// value, either the ALU result or the extracted load data. It commits that value
// into the register file, counts committed writes, and latches a sticky fault
// on misaligned loads. Two combinational read ports serve decode. Each port
// bypasses the write being committed this cycle.
//
// Ports:
//   Clk          in   1     pipeline clock, rising edge
//   Reset        in   1     asynchronous active-high reset
//   RegWriteW    in   1     write enable from MEM/WB
//   MemtoRegW    in   1     1 = load data, 0 = ALU result
//   MemDataW     in   DW    raw memory word
//   ALUResultW   in   DW    ALU result / load byte address
//   RegisterRdW  in   5     destination register
//   LsW          in   3     load type
//   RA1, RA2     in   5     decode read addresses
//   RD1, RD2     out  DW    decode read data
//   WBData       out  DW    write-back value (forwarding source)
//   WBWriteEn    out  1     effective write enable
//   AlignFault   out  1     sticky misaligned-load flag
//   WriteCount   out  CNTW  committed register writes, wraps
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int NREG = 32,
    parameter int DW   = wb_regfile_pkg::DW,
    parameter int CNTW = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            RegWriteW,
    input  logic            MemtoRegW,
    input  logic [DW-1:0]   MemDataW,
    input  logic [DW-1:0]   ALUResultW,
    input  logic [4:0]      RegisterRdW,
    input  logic [2:0]      LsW,
    input  logic [4:0]      RA1,
    input  logic [4:0]      RA2,
    output logic [DW-1:0]   RD1,
    output logic [DW-1:0]   RD2,
    output logic [DW-1:0]   WBData,
    output logic            WBWriteEn,
    output logic            AlignFault,
    output logic [CNTW-1:0] WriteCount
);

    import wb_regfile_pkg::*;

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] load_data;
    logic          misalign;
    logic          fault;

    load_ext u_load_ext (
        .mem_data (MemDataW),
        .off      (ALUResultW[1:0]),
        .ls       (LsW),
        .data     (load_data),
        .misalign (misalign)
    );

    // Misalignment only counts for a real load that would write a register.
    assign fault     = RegWriteW & MemtoRegW & misalign;
    assign WBData    = MemtoRegW ? load_data : ALUResultW;
    assign WBWriteEn = RegWriteW & (RegisterRdW != REG_ZERO) & ~fault;

    // Register 0 reads as zero regardless of array contents. The bypass is
    // blocked while Reset is high so reads show the zeroed state.
    assign RD1 = (RA1 == REG_ZERO)                               ? '0     :
                 (WBWriteEn && !Reset && (RA1 == RegisterRdW))   ? WBData :
                                                                   regs[RA1];
    assign RD2 = (RA2 == REG_ZERO)                               ? '0     :
                 (WBWriteEn && !Reset && (RA2 == RegisterRdW))   ? WBData :
                                                                   regs[RA2];

    // NOTE: the array is reset explicitly because registers must read zero right after Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            AlignFault <= 1'b0;
            WriteCount <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every state update on the same edge snapshot.
            if (WBWriteEn) begin
                regs[RegisterRdW] <= WBData;
                WriteCount        <= WriteCount + CNTW'(1);
            end
            if (fault) begin
                AlignFault <= 1'b1;
            end
        end
    end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Scoreboard bench for wb_regfile. It is built with CNTW=4 so the counter wrap
// is reachable. The stimulus drives inputs 1 time unit after the rising edge
// and queues the expected values. The monitor drains the queue on each falling
// edge and compares the values against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    localparam int CNTW = 4;

    logic            Clk;
    logic            Reset;
    logic            RegWriteW;
    logic            MemtoRegW;
    logic [31:0]     MemDataW;
    logic [31:0]     ALUResultW;
    logic [4:0]      RegisterRdW;
    logic [2:0]      LsW;
    logic [4:0]      RA1;
    logic [4:0]      RA2;
    logic [31:0]     RD1;
    logic [31:0]     RD2;
    logic [31:0]     WBData;
    logic            WBWriteEn;
    logic            AlignFault;
    logic [CNTW-1:0] WriteCount;

    wb_regfile #(.NREG(32), .DW(32), .CNTW(CNTW)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .RegWriteW   (RegWriteW),
        .MemtoRegW   (MemtoRegW),
        .MemDataW    (MemDataW),
        .ALUResultW  (ALUResultW),
        .RegisterRdW (RegisterRdW),
        .LsW         (LsW),
        .RA1         (RA1),
        .RA2         (RA2),
        .RD1         (RD1),
        .RD2         (RD2),
        .WBData      (WBData),
        .WBWriteEn   (WBWriteEn),
        .AlignFault  (AlignFault),
        .WriteCount  (WriteCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef enum {S_RD1, S_RD2, S_WBD, S_WEN, S_FLT, S_CNT} sig_e;
    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic expect_val(input string name, input sig_e sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge Clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sig)
                    S_RD1:   act = RD1;
                    S_RD2:   act = RD2;
                    S_WBD:   act = WBData;
                    S_WEN:   act = {31'd0, WBWriteEn};
                    S_FLT:   act = {31'd0, AlignFault};
                    default: act = 32'(WriteCount);
                endcase
                check(e.name, act, e.exp);
            end
        end
    end

    // Load extension vectors on MemDataW = 0x80FF7F01
    logic [2:0]  lv_ls  [7] = '{LS_LB, LS_LBU, LS_LB, LS_LH, LS_LHU, LS_LW, 3'b111};
    logic [1:0]  lv_off [7] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    logic [31:0] lv_exp [7] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F,
                                32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};

    initial begin
        Reset = 1'b1; RegWriteW = 1'b0; MemtoRegW = 1'b0; MemDataW = '0;
        ALUResultW = '0; RegisterRdW = '0; LsW = '0; RA1 = 5'd3; RA2 = 5'd31;
        expect_val("init_cnt", S_CNT, 0);
        expect_val("init_flt", S_FLT, 0);
        expect_val("init_rd1", S_RD1, 0);
        step; step;
        Reset = 1'b0;

        // ALU write with same-cycle bypass on both ports
        RegWriteW = 1'b1; MemtoRegW = 1'b0; ALUResultW = 32'h12345678;
        RegisterRdW = 5'd5; RA1 = 5'd5; RA2 = 5'd5;
        expect_val("alu_bypass_rd1", S_RD1, 32'h12345678);
        expect_val("alu_bypass_rd2", S_RD2, 32'h12345678);
        expect_val("alu_wen", S_WEN, 1);
        expect_val("alu_cnt_pre", S_CNT, 0);
        step;
        RegWriteW = 1'b0; RA2 = 5'd0;
        expect_val("alu_rd1_post", S_RD1, 32'h12345678);
        expect_val("alu_rd2_zero", S_RD2, 0);
        expect_val("alu_cnt_post", S_CNT, 1);

        // Load extraction, bypassed into RD1 and committed to regs 10..16
        for (int i = 0; i < 7; i++) begin
            step;
            RegWriteW = 1'b1; MemtoRegW = 1'b1; MemDataW = 32'h80FF7F01;
            LsW = lv_ls[i]; ALUResultW = {30'h00000800, lv_off[i]};
            RegisterRdW = 5'(10 + i); RA1 = 5'(10 + i); RA2 = 5'd0;
            expect_val($sformatf("ld%0d_wbd", i), S_WBD, lv_exp[i]);
            expect_val($sformatf("ld%0d_rd1", i), S_RD1, lv_exp[i]);
            expect_val($sformatf("ld%0d_wen", i), S_WEN, 1);
        end
        for (int i = 0; i < 7; i++) begin
            step;
            RegWriteW = 1'b0; MemtoRegW = 1'b0; RA1 = 5'(10 + i);
            expect_val($sformatf("ld%0d_readback", i), S_RD1, lv_exp[i]);
        end
        expect_val("ld_cnt", S_CNT, 8);

        // Write to register 0 is discarded
        step;
        RegWriteW = 1'b1; MemtoRegW = 1'b0; ALUResultW = 32'hDEADBEEF;
        RegisterRdW = 5'd0; RA1 = 5'd0; RA2 = 5'd0;
        expect_val("r0_rd1", S_RD1, 0);
        expect_val("r0_wen", S_WEN, 0);
        expect_val("r0_wbd", S_WBD, 32'hDEADBEEF);
        step;
        RegWriteW = 1'b0;
        expect_val("r0_cnt", S_CNT, 8);
        expect_val("r0_rd2", S_RD2, 0);

        // Misaligned loads: reg7 preset, then lw at 0x1002 and lh at 0x1001
        step;
        RegWriteW = 1'b1; ALUResultW = 32'h0000AAAA; RegisterRdW = 5'd7;
        step;
        MemtoRegW = 1'b1; LsW = LS_LW; ALUResultW = 32'h00001002;
        MemDataW = 32'h11223344; RA1 = 5'd7;
        expect_val("mis_lw_wen", S_WEN, 0);
        expect_val("mis_lw_rd1", S_RD1, 32'h0000AAAA);
        expect_val("mis_flt_pre", S_FLT, 0);
        step;
        LsW = LS_LH; ALUResultW = 32'h00001001;
        expect_val("mis_lh_wen", S_WEN, 0);
        expect_val("mis_flt_post", S_FLT, 1);
        expect_val("mis_rd1_kept", S_RD1, 32'h0000AAAA);
        expect_val("mis_cnt", S_CNT, 9);
        step;
        LsW = LS_LHU; ALUResultW = 32'h00001002; RegisterRdW = 5'd8; RA1 = 5'd8;
        expect_val("lhu_hi_wbd", S_WBD, 32'h00001122);
        expect_val("lhu_hi_wen", S_WEN, 1);
        step;
        RegWriteW = 1'b0; MemtoRegW = 1'b0; RA1 = 5'd7; RA2 = 5'd8;
        expect_val("after_rd7", S_RD1, 32'h0000AAAA);
        expect_val("after_rd8", S_RD2, 32'h00001122);
        expect_val("flt_sticky", S_FLT, 1);
        expect_val("after_cnt", S_CNT, 10);

        // Reset asserted mid-cycle clears everything immediately
        @(posedge Clk);
        #2 Reset = 1'b1;
        expect_val("rst_rd7", S_RD1, 0);
        expect_val("rst_rd8", S_RD2, 0);
        expect_val("rst_cnt", S_CNT, 0);
        expect_val("rst_flt", S_FLT, 0);
        for (int i = 0; i < 16; i++) begin
            step;
            RA1 = 5'(2 * i); RA2 = 5'(2 * i + 1);
            expect_val($sformatf("rst_rd_r%0d", 2 * i), S_RD1, 0);
            expect_val($sformatf("rst_rd_r%0d", 2 * i + 1), S_RD2, 0);
        end
        step;
        Reset = 1'b0;

        // 17 valid writes wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            RegWriteW = 1'b1; MemtoRegW = 1'b0; ALUResultW = 32'(100 + i);
            RegisterRdW = 5'((i % 31) + 1);
            step;
        end
        RegWriteW = 1'b0; RA1 = 5'd1; RA2 = 5'd17;
        expect_val("wrap_cnt", S_CNT, 1);
        expect_val("wrap_r1", S_RD1, 100);
        expect_val("wrap_r17", S_RD2, 116);

        step; step;
        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_wb_regfile
